// File: rtl/pipelined_divider.sv
// Pipelined restoring divider.
//
// Divides a 2N-bit unsigned dividend by an N-bit unsigned divisor. It produces one quotient
// bit per stage, MSB first, across 2N iterate stages behind a capture stage. It accepts one
// operation per cycle, and each result appears exactly 2N+1 cycles after its data_rdy pulse.
//
// Ports:
//   clk       rising-edge clock
//   rstn      synchronous reset, active-high; clears every pipeline register
//   data_rdy  operands valid this cycle
//   dividend  2N-bit unsigned dividend
//   divisor   N-bit unsigned divisor
//   res_rdy   single-cycle pulse marking a valid quot/rem/div_zero
//   quot      2N-bit unsigned quotient (all ones on divide by zero)
//   rem       N-bit unsigned remainder (dividend[N-1:0] on divide by zero)
//   div_zero  divisor of this result was zero
//
// Stages that carry no valid operation hold zeros, so the outputs read 0 whenever
// res_rdy is 0.

module pipelined_divider #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           data_rdy,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           res_rdy,
    output logic [2*N-1:0] quot,
    output logic [N-1:0]   rem,
    output logic           div_zero
);

    localparam int S = 2 * N;

    // Stage 0 is the capture stage. Stages 1..S each resolve one quotient bit.
    logic           valid_q [0:S];
    logic           valid_d [0:S];
    logic           zero_q  [0:S];
    logic           zero_d  [0:S];

    // Stage S has no later consumer of the operands, so operands stop at stage S-1.
    // The dividend moves left by one bit per stage, so the next bit to consume is
    // always in the MSB position.
    logic [S-1:0]   dvd_q   [0:S-1];
    logic [S-1:0]   dvd_d   [0:S-1];
    logic [N-1:0]   dvs_q   [0:S-1];
    logic [N-1:0]   dvs_d   [0:S-1];

    // The trial value is N+1 bits wide, but only its low N bits feed the next stage.
    // For a non-zero divisor the partial remainder is always below the divisor.
    // For a zero divisor the discarded top bit is never examined again.
    // Storing N bits per stage is therefore enough.
    logic [N-1:0]   prem_q  [1:S];
    logic [N-1:0]   prem_d  [1:S];
    logic [S-1:0]   quot_q  [1:S];
    logic [S-1:0]   quot_d  [1:S];

    // Partial remainder and quotient seen by each iterate stage. Stage 1 starts from zero.
    logic [N-1:0]   prem_in [1:S];
    logic [S-2:0]   quot_in [1:S];

    always_comb begin
        prem_in = '{default: '0};
        quot_in = '{default: '0};
        for (int i = 2; i <= S; i++) begin
            prem_in[i] = prem_q[i-1];
            quot_in[i] = quot_q[i-1][S-2:0];
        end
    end

    always_comb begin
        logic [N:0] trial;

        trial   = '0;
        valid_d = '{default: 1'b0};
        zero_d  = '{default: 1'b0};
        dvd_d   = '{default: '0};
        dvs_d   = '{default: '0};
        prem_d  = '{default: '0};
        quot_d  = '{default: '0};

        // Capture stage.
        valid_d[0] = data_rdy;
        if (data_rdy) begin
            dvd_d[0]  = dividend;
            dvs_d[0]  = divisor;
            zero_d[0] = (divisor == '0);
        end

        // Iterate stages. With a zero divisor, every trial value is >= 0. The quotient
        // therefore fills with ones, and the low N dividend bits end up as the remainder.
        for (int i = 1; i <= S; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                zero_d[i] = zero_q[i-1];
                trial     = {prem_in[i], dvd_q[i-1][S-1]};
                if (trial >= {1'b0, dvs_q[i-1]}) begin
                    prem_d[i] = trial[N-1:0] - dvs_q[i-1];
                    quot_d[i] = {quot_in[i], 1'b1};
                end else begin
                    prem_d[i] = trial[N-1:0];
                    quot_d[i] = {quot_in[i], 1'b0};
                end
            end
        end

        // Operand transport into stages 1..S-1.
        for (int i = 1; i < S; i++) begin
            if (valid_q[i-1]) begin
                dvd_d[i] = {dvd_q[i-1][S-2:0], 1'b0};
                dvs_d[i] = dvs_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            valid_q <= '{default: 1'b0};
            zero_q  <= '{default: 1'b0};
            dvd_q   <= '{default: '0};
            dvs_q   <= '{default: '0};
            prem_q  <= '{default: '0};
            quot_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
        end
    end

    assign res_rdy  = valid_q[S];
    assign quot     = quot_q[S];
    assign rem      = prem_q[S];
    assign div_zero = zero_q[S];

endmodule

// File: doc/pipelined_divider.md
Name: pipelined_divider

Overview:
- Pipelined restoring divider; the inverse of the team's pipelined shift-add multiplier.
- Takes a 2N-bit unsigned dividend and an N-bit unsigned divisor. Produces a 2N-bit quotient and an N-bit remainder.
- Fixed latency, one result bit per pipeline stage, one new operation accepted every cycle.
- Uses the same data_rdy/res_rdy valid-pulse convention as the multiplier, so a multiply result can feed straight back in for checking.

Parameters:
- N, 4, divisor and remainder width; dividend and quotient are 2N bits; number of iterate stages is 2N.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous reset, active-high: rstn=1 at a rising clk edge clears all state
- data_rdy  input  1  operands valid this cycle
- dividend  input  2N  unsigned dividend
- divisor  input  N  unsigned divisor
- res_rdy  output  1  quotient/remainder/div_zero valid this cycle (single-cycle pulse per operation)
- quot  output  2N  unsigned quotient
- rem  output  N  unsigned remainder
- div_zero  output  1  divisor was zero for this result

Behaviour:
- Reset: on any edge with rstn=1, every pipeline register clears to 0, including valid bits, partial remainders, quotient shifts and the zero flag.
  - Outputs after reset: res_rdy=0, quot=0, rem=0, div_zero=0.
  - Operations in flight are discarded, with no partial results.
  - Reset has priority over data_rdy on the same edge.
- Structure:
  - Stage 0 is the capture register: valid, dividend, divisor, and zero flag = (divisor==0).
  - Stages 1..2N each resolve one quotient bit, MSB first.
  - Outputs are driven directly from stage 2N registers.
- Latency: data_rdy=1 in cycle c gives res_rdy=1 in cycle c+2N+1 (c+9 for N=4).
- Throughput: one operation per cycle, no stalls, no backpressure. Back-to-back inputs give back-to-back res_rdy pulses, in order.
- Stage i (i=1..2N):
  - Partial remainder P is N+1 bits.
  - T = {P[N-1:0], next dividend bit}.
  - If T >= {1'b0, divisor}: P = T - divisor and the quotient bit = 1. Otherwise P = T and the quotient bit = 0.
  - Dividend and divisor travel down the pipeline with their valid bit.
- Valid gating: when a stage's incoming valid is 0, it loads 0 into all of its data registers. Outputs therefore read 0 whenever res_rdy=0, as in the multiplier.
- Divide by zero:
  - div_zero=1, quot = all ones (2^(2N)-1), rem = dividend[N-1:0].
  - Raised together with res_rdy.
  - No other side effects; neighbouring operations are unaffected.
- Arithmetic invariant for divisor!=0: dividend == quot*divisor + rem, with rem < divisor. The quotient cannot overflow because its width is 2N.
- Boundary conditions:
  - dividend=0 gives quot=0, rem=0.
  - divisor=1 gives quot=dividend, rem=0.
  - divisor > dividend gives quot=0, rem=dividend.
  - data_rdy toggling every cycle must produce the matching alternating res_rdy pattern, with no bleed between slots.
- Target size: about 150-300 lines of RTL. Implement the stages as a generate loop or per-stage always blocks; no combinational path from input to output.

Test Plan:
- Reset then idle: rstn=1 for 2 cycles, then data_rdy=0 for 20 cycles -> res_rdy=0, quot=0, rem=0, div_zero=0 throughout.
- Single op: dividend=200, divisor=7, data_rdy pulsed in cycle c -> in cycle c+9, res_rdy=1, quot=28, rem=4, div_zero=0; res_rdy=0 in cycles c+8 and c+10.
- Edge values back-to-back in consecutive cycles:
  - 255/1 -> 255 r0
  - 0/5 -> 0 r0
  - 3/15 -> 0 r3
  - 225/15 -> 15 r0
  - Required: four consecutive res_rdy cycles with these results, in order.
- Divide by zero: 100/0 followed next cycle by 100/3 -> first result quot=255, rem=4, div_zero=1; second result quot=33, rem=1, div_zero=0.
- Reset mid-flight: issue 3 ops, assert rstn=1 for 1 cycle 4 cycles later -> no res_rdy pulses for those ops; an op issued after reset returns correctly at +9.
- Random soak: 10,000 random dividend/divisor pairs with random data_rdy at about 70% density -> scoreboard matches the reference model, including div_zero cases, in order and at latency exactly 9.
